// File: rtl/mux4_rr_arbiter_if.sv
// Requester/arbiter bundle for mux4_rr_arbiter: request vector in, registered grant and mux selects out.
`timescale 1ns/1ps
interface mux4_rr_arbiter_if #(
  parameter int unsigned CNT_W = 3
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             s0;
  logic             s1;
  logic             valid;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req,
    input  gnt, s0, s1, valid, hold_cnt
  );

  modport slave (
    input  req,
    output gnt, s0, s1, valid, hold_cnt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the selects of a shared 4-bit 4:1 mux, with MAX_HOLD grant bound.
// Optional: define MUX_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (req[0] highest).
`timescale 1ns/1ps
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q;
  logic [1:0]       owner_q;
  logic [3:0]       gnt_q;
  logic             valid_q;
  logic [CNT_W-1:0] hold_q;

  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic             preempt_ok;

`ifdef MUX_ARB_FIXED_PRIO_EN
  logic [3:0] cand_req;

  // Lowest set index wins; while granted the owner is masked so only others are candidates.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_req = bus.req;
    if (state_q == GRANT) cand_req[owner_q] = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pick_vld && cand_req[i]) begin
        pick_vld = 1'b1;
        pick_idx = 2'(i);
      end
    end
    preempt_ok = pick_vld && (pick_idx < owner_q);
  end
`else
  logic [1:0] last_q;
  logic [1:0] base;
  logic [1:0] cand;

  // Scan starts after the owner while granted (owner excluded), after last when idle.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    base     = (state_q == GRANT) ? owner_q : last_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!pick_vld && !((state_q == GRANT) && (cand == owner_q)) && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    preempt_ok = pick_vld;
  end
`endif

  // owner_q doubles as the select register, so it is left untouched on the way to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= GRANT;
            owner_q <= pick_idx;
            gnt_q   <= 4'b0001 << pick_idx;
            valid_q <= 1'b1;
            hold_q  <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!bus.req[owner_q]) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_q <= owner_q;
`endif
            if (pick_vld) begin
              owner_q <= pick_idx;
              gnt_q   <= 4'b0001 << pick_idx;
              hold_q  <= CNT_W'(1);
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              valid_q <= 1'b0;
              hold_q  <= '0;
            end
          end else if (hold_q < CNT_W'(MAX_HOLD)) begin
            hold_q <= hold_q + CNT_W'(1);
          end else if (preempt_ok) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_q <= owner_q;
`endif
            owner_q <= pick_idx;
            gnt_q   <= 4'b0001 << pick_idx;
            hold_q  <= CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.s0       = owner_q[0];
  assign bus.s1       = owner_q[1];
  assign bus.valid    = valid_q;
  assign bus.hold_cnt = hold_q;

endmodule
